// File: rtl/alu_pkg.sv
// Shared opcode, state and helper definitions for the ALU
// request arbiter and the ALU it fronts.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLR  = 4'b0101;
  localparam logic [3:0] OP_SLL  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;

  localparam int NUM_OPS = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic is_legal_op(input logic [3:0] op);
    return op < 4'(NUM_OPS);
  endfunction

endpackage

// File: rtl/alu_req_arbiter_wrapper.sv
// Combinational 64-bit ALU, ops 0-9; undefined ops
// produce zero (the arbiter masks them anyway).
module wrapper
  import alu_pkg::*;
(
  input  logic [63:0] i_a,
  input  logic [63:0] i_b,
  input  logic [3:0]  i_op,
  output logic [63:0] o_result
);

  logic [5:0] w_sh;

  assign w_sh = i_b[5:0];

  always_comb begin
    o_result = '0;
    unique case (i_op)
      OP_ADD:  o_result = i_a + i_b;
      OP_SUB:  o_result = i_a - i_b;
      OP_AND:  o_result = i_a & i_b;
      OP_OR:   o_result = i_a | i_b;
      OP_XOR:  o_result = i_a ^ i_b;
      OP_SLR:  o_result = i_a >> w_sh;
      OP_SLL:  o_result = i_a << w_sh;
      OP_SRA:  o_result = $signed(i_a) >>> w_sh;
      OP_SLT:  o_result = {63'd0, $signed(i_a) < $signed(i_b)};
      OP_SLTU: o_result = {63'd0, i_a < i_b};
      default: o_result = '0;
    endcase
  end

endmodule

// File: rtl/alu_req_arbiter.sv
// Round-robin front end that shares one ALU between two
// requesters: grant, execute from registers, respond.
module alu_req_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int OP_W   = 4,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OP_W-1:0]   req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OP_W-1:0]   req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              resp0_valid,
  input  logic              resp0_ready,
  output logic [DATA_W-1:0] resp0_result,
  output logic              resp0_err,
  output logic              resp1_valid,
  input  logic              resp1_ready,
  output logic [DATA_W-1:0] resp1_result,
  output logic              resp1_err,
  output logic              busy,
  output logic [CNT_W-1:0]  op_count
);

  state_t            r_state;
  logic [OP_W-1:0]   r_op;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic              r_owner;
  logic              r_last;
  logic [DATA_W-1:0] r_res;
  logic              r_err;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_idle;
  logic              w_g0;
  logic              w_g1;
  logic              w_hs0;
  logic              w_hs1;
  logic              w_done;
  logic [DATA_W-1:0] w_alu;

  wrapper u_alu (
    .i_a      (r_a),
    .i_b      (r_b),
    .i_op     (r_op),
    .o_result (w_alu)
  );

  // On a tie the requester that was not served last wins.
  assign w_idle = (r_state == IDLE) && !rst;
  assign w_g0   = req0_valid && (!req1_valid || r_last);
  assign w_g1   = req1_valid && (!req0_valid || !r_last);

  assign req0_ready = w_idle && w_g0;
  assign req1_ready = w_idle && w_g1;
  assign w_hs0      = req0_valid && req0_ready;
  assign w_hs1      = req1_valid && req1_ready;

  assign resp0_valid  = !rst && (r_state == RESP) && !r_owner;
  assign resp1_valid  = !rst && (r_state == RESP) && r_owner;
  assign resp0_result = resp0_valid ? r_res : '0;
  assign resp1_result = resp1_valid ? r_res : '0;
  assign resp0_err    = resp0_valid && r_err;
  assign resp1_err    = resp1_valid && r_err;

  assign w_done = (resp0_valid && resp0_ready) ||
                  (resp1_valid && resp1_ready);

  assign busy     = r_state != IDLE;
  assign op_count = r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_owner <= 1'b0;
      r_last  <= 1'b1;
      r_res   <= '0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_hs0) begin
            r_op    <= req0_op;
            r_a     <= req0_a;
            r_b     <= req0_b;
            r_owner <= 1'b0;
            r_last  <= 1'b0;
            r_state <= EXEC;
          end else if (w_hs1) begin
            r_op    <= req1_op;
            r_a     <= req1_a;
            r_b     <= req1_b;
            r_owner <= 1'b1;
            r_last  <= 1'b1;
            r_state <= EXEC;
          end
        end
        EXEC: begin
          r_res   <= is_legal_op(r_op) ? w_alu : '0;
          r_err   <= !is_legal_op(r_op);
          r_state <= RESP;
        end
        RESP: begin
          if (w_done) begin
            r_cnt   <= r_cnt + 1'b1;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
